// File: rtl/fft_job_scheduler.sv
// FFT job scheduler: queues per-channel FFT jobs in a FIFO, dispatches them one at a time to a
// single engine and tracks per-channel done/error/scale status with a watchdog on the engine.
module fft_job_scheduler #(
    parameter int unsigned NUM_CHANNELS        = 4,
    parameter int unsigned QUEUE_DEPTH         = 4,
    parameter int unsigned FFT_MAX_LENGTH_LOG2 = 12,
    parameter int unsigned FFT_MIN_LENGTH_LOG2 = 8,
    parameter int unsigned TIMEOUT_WIDTH       = 16,
    localparam int unsigned CW = $clog2(NUM_CHANNELS),
    localparam int unsigned QW = $clog2(QUEUE_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      job_valid_i,
    output logic                      job_ready_o,
    input  logic [CW-1:0]             job_chan_i,
    input  logic [3:0]                job_len_log2_i,
    input  logic                      job_rescale_i,
    output logic                      fft_start_o,
    output logic                      fft_reset_o,
    output logic [11:0]               fft_length_log2_o,
    output logic                      fft_rescale_en_o,
    input  logic                      fft_busy_i,
    input  logic                      fft_done_i,
    input  logic                      fft_error_i,
    input  logic [7:0]                scale_factor_i,
    input  logic [TIMEOUT_WIDTH-1:0]  timeout_cycles_i,
    input  logic                      flush_i,
    input  logic [2*NUM_CHANNELS-1:0] int_enable_i,
    input  logic [NUM_CHANNELS-1:0]   chan_clear_i,
    output logic [NUM_CHANNELS-1:0]   chan_done_o,
    output logic [NUM_CHANNELS-1:0]   chan_error_o,
    output logic [8*NUM_CHANNELS-1:0] chan_scale_o,
    output logic [CW-1:0]             active_chan_o,
    output logic                      busy_o,
    output logic [QW:0]               queue_count_o,
    output logic                      irq_done_o,
    output logic                      irq_error_o
);

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_t;

    localparam int unsigned EW = CW + 5;
    localparam logic [QW:0] QDEPTH = QUEUE_DEPTH[QW:0];

    state_t                    r_state;
    logic [EW-1:0]             r_mem [QUEUE_DEPTH];
    logic [QW-1:0]             r_wptr;
    logic [QW-1:0]             r_rptr;
    logic [QW:0]               r_count;
    logic                      r_start;
    logic                      r_freset;
    logic                      r_rescale;
    logic [3:0]                r_len;
    logic [CW-1:0]             r_chan;
    logic [TIMEOUT_WIDTH-1:0]  r_wdog;
    logic [NUM_CHANNELS-1:0]   r_done;
    logic [NUM_CHANNELS-1:0]   r_err;
    logic [8*NUM_CHANNELS-1:0] r_scale;

    logic                      w_len_ok;
    logic                      w_accept;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_tmo;
    logic                      w_eng_done;
    logic                      w_eng_err;
    logic [EW-1:0]             w_head;
    logic [NUM_CHANNELS-1:0]   w_done_set;
    logic [NUM_CHANNELS-1:0]   w_err_set;
    logic                      w_unused;

    // Engine busy is reported status only; dispatch never waits on it.
    assign w_unused = fft_busy_i;

    assign job_ready_o = (r_count < QDEPTH) && !flush_i;
    assign w_len_ok    = ({28'd0, job_len_log2_i} >= FFT_MIN_LENGTH_LOG2) &&
                         ({28'd0, job_len_log2_i} <= FFT_MAX_LENGTH_LOG2);
    assign w_accept    = job_valid_i && job_ready_o;
    assign w_push      = w_accept && w_len_ok;
    assign w_pop       = (r_state == StIdle) && (r_count != '0) && !flush_i;
    assign w_head      = r_mem[r_rptr];

    // Error beats done beats watchdog; flush overrides all and sets nothing.
    assign w_tmo      = (r_state == StWait) && (timeout_cycles_i != '0) &&
                        (r_wdog == timeout_cycles_i);
    assign w_eng_done = (r_state == StWait) && !flush_i && fft_done_i && !fft_error_i;
    assign w_eng_err  = (r_state == StWait) && !flush_i &&
                        (fft_error_i || (w_tmo && !fft_done_i));

    always_comb begin
        w_done_set = '0;
        w_err_set  = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (w_accept && !w_len_ok && (job_chan_i == CW'(c))) begin
                w_err_set[c] = 1'b1;
            end
            if (r_chan == CW'(c)) begin
                w_done_set[c] = w_eng_done;
                w_err_set[c]  = w_err_set[c] | w_eng_err;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {job_rescale_i, job_len_log2_i, job_chan_i};
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= StIdle;
            r_start   <= 1'b0;
            r_freset  <= 1'b0;
            r_rescale <= 1'b0;
            r_len     <= '0;
            r_chan    <= '0;
            r_wdog    <= '0;
        end else begin
            r_start  <= 1'b0;
            r_freset <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_chan    <= w_head[CW-1:0];
                        r_len     <= w_head[CW+3:CW];
                        r_rescale <= w_head[EW-1];
                        r_start   <= 1'b1;
                        r_state   <= StStart;
                    end
                end
                StStart: begin
                    r_wdog <= '0;
                    if (flush_i) begin
                        r_freset <= 1'b1;
                        r_state  <= StIdle;
                    end else begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (flush_i) begin
                        r_freset <= 1'b1;
                        r_state  <= StIdle;
                    end else if (fft_error_i || fft_done_i) begin
                        r_state <= StIdle;
                    end else if (w_tmo) begin
                        r_freset <= 1'b1;
                        r_state  <= StIdle;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Set wins over a coincident W1C clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_done  <= '0;
            r_err   <= '0;
            r_scale <= '0;
        end else begin
            r_done <= (r_done & ~chan_clear_i) | w_done_set;
            r_err  <= (r_err & ~chan_clear_i) | w_err_set;
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (w_done_set[c]) begin
                    r_scale[8*c +: 8] <= scale_factor_i;
                end
            end
        end
    end

    assign fft_start_o       = r_start;
    assign fft_reset_o       = r_freset;
    assign fft_length_log2_o = {8'd0, r_len};
    assign fft_rescale_en_o  = r_rescale;
    assign chan_done_o       = r_done;
    assign chan_error_o      = r_err;
    assign chan_scale_o      = r_scale;
    assign active_chan_o     = r_chan;
    assign busy_o            = (r_state != StIdle) || (r_count != '0);
    assign queue_count_o     = r_count;
    assign irq_done_o        = |(r_done & int_enable_i[NUM_CHANNELS-1:0]);
    assign irq_error_o       = |(r_err & int_enable_i[2*NUM_CHANNELS-1:NUM_CHANNELS]);

endmodule

// File: tb/tb_fft_job_scheduler.sv
// Self-checking bench for fft_job_scheduler: dispatch order is tracked with a scoreboard of
// expected jobs against jobs observed on fft_start_o.
module tb_fft_job_scheduler;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        job_valid_i;
    logic        job_ready_o;
    logic [1:0]  job_chan_i;
    logic [3:0]  job_len_log2_i;
    logic        job_rescale_i;
    logic        fft_start_o;
    logic        fft_reset_o;
    logic [11:0] fft_length_log2_o;
    logic        fft_rescale_en_o;
    logic        fft_busy_i;
    logic        fft_done_i;
    logic        fft_error_i;
    logic [7:0]  scale_factor_i;
    logic [15:0] timeout_cycles_i;
    logic        flush_i;
    logic [7:0]  int_enable_i;
    logic [3:0]  chan_clear_i;
    logic [3:0]  chan_done_o;
    logic [3:0]  chan_error_o;
    logic [31:0] chan_scale_o;
    logic [1:0]  active_chan_o;
    logic        busy_o;
    logic [2:0]  queue_count_o;
    logic        irq_done_o;
    logic        irq_error_o;

    int          total = 0;
    int          bad = 0;
    logic [6:0]  sb[$];
    logic [6:0]  obs[$];
    logic [7:0]  exp_scale [4];

    fft_job_scheduler dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .job_valid_i       (job_valid_i),
        .job_ready_o       (job_ready_o),
        .job_chan_i        (job_chan_i),
        .job_len_log2_i    (job_len_log2_i),
        .job_rescale_i     (job_rescale_i),
        .fft_start_o       (fft_start_o),
        .fft_reset_o       (fft_reset_o),
        .fft_length_log2_o (fft_length_log2_o),
        .fft_rescale_en_o  (fft_rescale_en_o),
        .fft_busy_i        (fft_busy_i),
        .fft_done_i        (fft_done_i),
        .fft_error_i       (fft_error_i),
        .scale_factor_i    (scale_factor_i),
        .timeout_cycles_i  (timeout_cycles_i),
        .flush_i           (flush_i),
        .int_enable_i      (int_enable_i),
        .chan_clear_i      (chan_clear_i),
        .chan_done_o       (chan_done_o),
        .chan_error_o      (chan_error_o),
        .chan_scale_o      (chan_scale_o),
        .active_chan_o     (active_chan_o),
        .busy_o            (busy_o),
        .queue_count_o     (queue_count_o),
        .irq_done_o        (irq_done_o),
        .irq_error_o       (irq_error_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (fft_start_o === 1'b1) begin
            obs.push_back({fft_rescale_en_o, fft_length_log2_o[3:0], active_chan_o});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Only lengths 8..12 are expected to be queued and dispatched.
    task automatic send_job(input logic [1:0] c, input logic [3:0] l, input logic r);
        job_valid_i    = 1'b1;
        job_chan_i     = c;
        job_len_log2_i = l;
        job_rescale_i  = r;
        if (l >= 4'd8 && l <= 4'd12) sb.push_back({r, l, c});
        step(1);
        job_valid_i = 1'b0;
    endtask

    task automatic wait_obs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (obs.size() != 0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic clear_all();
        chan_clear_i = 4'hF;
        step(1);
        chan_clear_i = 4'h0;
    endtask

    task automatic check_dispatch(input string name);
        bit ok;
        logic [6:0] e;
        logic [6:0] o;
        wait_obs(ok);
        total++;
        if (!ok || sb.size() == 0) begin
            bad++;
            $display("FAIL %s: no dispatch observed (obs=%0d sb=%0d)", name, obs.size(), sb.size());
        end else begin
            e = sb.pop_front();
            o = obs.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL %s: dispatched %h, expected %h", name, o, e);
            end
        end
    endtask

    task automatic test_reset();
        job_valid_i = 0; job_chan_i = 0; job_len_log2_i = 0; job_rescale_i = 0;
        fft_busy_i = 0; fft_done_i = 0; fft_error_i = 0; scale_factor_i = 0;
        timeout_cycles_i = 0; flush_i = 0; int_enable_i = 0; chan_clear_i = 0;
        for (int i = 0; i < 4; i++) exp_scale[i] = 8'h00;
        reset_n_i = 1'b0;
        step(2);
        total++; if (fft_start_o !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", fft_start_o); end
        total++; if (fft_reset_o !== 1'b0) begin bad++; $display("FAIL rst_freset: got %b want 0", fft_reset_o); end
        total++; if (fft_length_log2_o !== 12'd0) begin bad++; $display("FAIL rst_len: got %0d want 0", fft_length_log2_o); end
        total++; if ({chan_done_o, chan_error_o} !== 8'h00) begin bad++; $display("FAIL rst_flags: got %h want 00", {chan_done_o, chan_error_o}); end
        total++; if (chan_scale_o !== 32'h0) begin bad++; $display("FAIL rst_scale: got %h want 0", chan_scale_o); end
        total++; if ({busy_o, queue_count_o, active_chan_o} !== 6'd0) begin bad++; $display("FAIL rst_busy_cnt_chan: got %b want 0", {busy_o, queue_count_o, active_chan_o}); end
        reset_n_i = 1'b1;
        step(1);
        total++; if (job_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", job_ready_o); end
    endtask

    task automatic test_basic();
        send_job(2'd2, 4'd10, 1'b1);
        total++; if (queue_count_o !== 3'd1) begin bad++; $display("FAIL basic_count: got %0d want 1", queue_count_o); end
        total++; if (fft_start_o !== 1'b0) begin bad++; $display("FAIL basic_start_early: got %b want 0", fft_start_o); end
        step(1);
        total++; if (fft_start_o !== 1'b1) begin bad++; $display("FAIL basic_start_n2: got %b want 1", fft_start_o); end
        total++; if (fft_length_log2_o !== 12'd10) begin bad++; $display("FAIL basic_len: got %0d want 10", fft_length_log2_o); end
        total++; if (fft_rescale_en_o !== 1'b1) begin bad++; $display("FAIL basic_rescale: got %b want 1", fft_rescale_en_o); end
        total++; if (active_chan_o !== 2'd2) begin bad++; $display("FAIL basic_chan: got %0d want 2", active_chan_o); end
        step(1);
        total++; if (fft_start_o !== 1'b0) begin bad++; $display("FAIL basic_start_pulse: got %b want 0", fft_start_o); end
        total++; if (fft_length_log2_o !== 12'd10) begin bad++; $display("FAIL basic_len_hold: got %0d want 10", fft_length_log2_o); end
        check_dispatch("basic_dispatch");
        fft_done_i = 1'b1; scale_factor_i = 8'd3;
        step(1);
        fft_done_i = 1'b0; scale_factor_i = 8'd0;
        exp_scale[2] = 8'd3;
        total++; if (chan_done_o !== 4'b0100) begin bad++; $display("FAIL basic_done: got %b want 0100", chan_done_o); end
        total++; if (chan_scale_o[23:16] !== exp_scale[2]) begin bad++; $display("FAIL basic_scale: got %0d want 3", chan_scale_o[23:16]); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_idle: got %b want 0", busy_o); end
        int_enable_i = 8'h00; #1;
        total++; if (irq_done_o !== 1'b0) begin bad++; $display("FAIL basic_irq_off: got %b want 0", irq_done_o); end
        int_enable_i = 8'h04; #1;
        total++; if (irq_done_o !== 1'b1) begin bad++; $display("FAIL basic_irq_on: got %b want 1", irq_done_o); end
        int_enable_i = 8'hFB; #1;
        total++; if (irq_done_o !== 1'b0) begin bad++; $display("FAIL basic_irq_other: got %b want 0", irq_done_o); end
        int_enable_i = 8'h00;
        chan_clear_i = 4'b0100;
        step(1);
        chan_clear_i = 4'b0000;
        total++; if (chan_done_o !== 4'b0000) begin bad++; $display("FAIL basic_clear: got %b want 0000", chan_done_o); end
    endtask

    task automatic test_illegal_len();
        int starts = 0;
        send_job(2'd1, 4'd7, 1'b0);
        total++; if (chan_error_o !== 4'b0010) begin bad++; $display("FAIL ill_len7_err: got %b want 0010", chan_error_o); end
        total++; if (queue_count_o !== 3'd0) begin bad++; $display("FAIL ill_len7_count: got %0d want 0", queue_count_o); end
        send_job(2'd3, 4'd13, 1'b0);
        total++; if (chan_error_o !== 4'b1010) begin bad++; $display("FAIL ill_len13_err: got %b want 1010", chan_error_o); end
        for (int i = 0; i < 6; i++) begin
            if (fft_start_o === 1'b1) starts++;
            step(1);
        end
        total++; if (starts + obs.size() != 0) begin bad++; $display("FAIL ill_no_start: got %0d starts want 0", starts + obs.size()); end
        int_enable_i = 8'h80; #1;
        total++; if (irq_error_o !== 1'b1) begin bad++; $display("FAIL ill_irq_on: got %b want 1", irq_error_o); end
        int_enable_i = 8'h5F; #1;
        total++; if (irq_error_o !== 1'b0) begin bad++; $display("FAIL ill_irq_gated: got %b want 0", irq_error_o); end
        int_enable_i = 8'h00;
        clear_all();
        total++; if (chan_error_o !== 4'b0000) begin bad++; $display("FAIL ill_clear: got %b want 0000", chan_error_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sc;
        logic [1:0] ch;
        fft_busy_i = 1'b1;
        send_job(2'd0, 4'd8, 1'b0);
        send_job(2'd1, 4'd12, 1'b1);
        send_job(2'd2, 4'd9, 1'b0);
        send_job(2'd3, 4'd11, 1'b1);
        send_job(2'd0, 4'd10, 1'b1);
        total++; if (job_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_ready_full: got %b want 0", job_ready_o); end
        total++; if (queue_count_o !== 3'd4) begin bad++; $display("FAIL b2b_count_full: got %0d want 4", queue_count_o); end
        job_valid_i = 1'b1; job_chan_i = 2'd1; job_len_log2_i = 4'd9;
        step(1);
        job_valid_i = 1'b0;
        total++; if (queue_count_o !== 3'd4) begin bad++; $display("FAIL b2b_no_overflow: got %0d want 4", queue_count_o); end
        for (int i = 0; i < 5; i++) begin
            ch = (sb.size() != 0) ? sb[0][1:0] : 2'd0;
            check_dispatch($sformatf("b2b_order%0d", i));
            sc = 8'h10 + 8'(i);
            fft_done_i = 1'b1; scale_factor_i = sc;
            step(1);
            fft_done_i = 1'b0;
            exp_scale[ch] = sc;
            total++; if (chan_done_o[ch] !== 1'b1) begin bad++; $display("FAIL b2b_done%0d: got %b want 1", i, chan_done_o[ch]); end
        end
        total++; if ({busy_o, queue_count_o} !== 4'd0) begin bad++; $display("FAIL b2b_drained: got %b want 0", {busy_o, queue_count_o}); end
        total++; if (chan_scale_o !== {exp_scale[3], exp_scale[2], exp_scale[1], exp_scale[0]}) begin
            bad++; $display("FAIL b2b_scales: got %h want %h", chan_scale_o, {exp_scale[3], exp_scale[2], exp_scale[1], exp_scale[0]});
        end
        fft_busy_i = 1'b0;
        clear_all();
    endtask

    task automatic test_timeout();
        int k = 0;
        timeout_cycles_i = 16'd20;
        send_job(2'd1, 4'd9, 1'b0);
        send_job(2'd2, 4'd10, 1'b0);
        total++; if (fft_start_o !== 1'b1) begin bad++; $display("FAIL tmo_start: got %b want 1", fft_start_o); end
        while (k < 40 && fft_reset_o !== 1'b1) begin
            step(1);
            k++;
        end
        total++; if (k != 22) begin bad++; $display("FAIL tmo_latency: got %0d cycles want 22", k); end
        total++; if (chan_error_o !== 4'b0010) begin bad++; $display("FAIL tmo_err: got %b want 0010", chan_error_o); end
        step(1);
        total++; if (fft_reset_o !== 1'b0) begin bad++; $display("FAIL tmo_reset_pulse: got %b want 0", fft_reset_o); end
        check_dispatch("tmo_first");
        check_dispatch("tmo_next");
        timeout_cycles_i = 16'd0;
        fft_done_i = 1'b1; scale_factor_i = 8'h21;
        step(1);
        fft_done_i = 1'b0;
        exp_scale[2] = 8'h21;
        total++; if (chan_done_o !== 4'b0100) begin bad++; $display("FAIL tmo_next_done: got %b want 0100", chan_done_o); end
        clear_all();
    endtask

    task automatic test_done_error();
        send_job(2'd3, 4'd11, 1'b1);
        check_dispatch("de_dispatch");
        fft_done_i = 1'b1; fft_error_i = 1'b1; scale_factor_i = 8'h55;
        step(1);
        fft_done_i = 1'b0; fft_error_i = 1'b0;
        total++; if (chan_error_o[3] !== 1'b1) begin bad++; $display("FAIL de_err: got %b want 1", chan_error_o[3]); end
        total++; if (chan_done_o[3] !== 1'b0) begin bad++; $display("FAIL de_no_done: got %b want 0", chan_done_o[3]); end
        total++; if (chan_scale_o[31:24] !== exp_scale[3]) begin bad++; $display("FAIL de_scale_kept: got %h want %h", chan_scale_o[31:24], exp_scale[3]); end
        int_enable_i = 8'h80; #1;
        total++; if (irq_error_o !== 1'b1) begin bad++; $display("FAIL de_irq_err_on: got %b want 1", irq_error_o); end
        int_enable_i = 8'h7F; #1;
        total++; if (irq_error_o !== 1'b0) begin bad++; $display("FAIL de_irq_err_off: got %b want 0", irq_error_o); end
        int_enable_i = 8'h00;
        send_job(2'd0, 4'd12, 1'b0);
        check_dispatch("clr_dispatch");
        fft_done_i = 1'b1; scale_factor_i = 8'h66; chan_clear_i = 4'b0001;
        step(1);
        fft_done_i = 1'b0; chan_clear_i = 4'b0000;
        exp_scale[0] = 8'h66;
        total++; if (chan_done_o[0] !== 1'b1) begin bad++; $display("FAIL clr_set_wins: got %b want 1", chan_done_o[0]); end
        total++; if (chan_scale_o[7:0] !== exp_scale[0]) begin bad++; $display("FAIL clr_scale: got %h want 66", chan_scale_o[7:0]); end
        int_enable_i = 8'h01; #1;
        total++; if (irq_done_o !== 1'b1) begin bad++; $display("FAIL clr_irq_on: got %b want 1", irq_done_o); end
        int_enable_i = 8'hFE; #1;
        total++; if (irq_done_o !== 1'b0) begin bad++; $display("FAIL clr_irq_off: got %b want 0", irq_done_o); end
        int_enable_i = 8'h00;
        clear_all();
    endtask

    task automatic test_flush();
        send_job(2'd0, 4'd8, 1'b0);
        send_job(2'd1, 4'd9, 1'b1);
        send_job(2'd2, 4'd10, 1'b0);
        send_job(2'd3, 4'd11, 1'b1);
        total++; if (queue_count_o !== 3'd3) begin bad++; $display("FAIL fl_count: got %0d want 3", queue_count_o); end
        flush_i = 1'b1; #1;
        total++; if (job_ready_o !== 1'b0) begin bad++; $display("FAIL fl_ready: got %b want 0", job_ready_o); end
        step(1);
        flush_i = 1'b0;
        total++; if (fft_reset_o !== 1'b1) begin bad++; $display("FAIL fl_reset: got %b want 1", fft_reset_o); end
        total++; if ({busy_o, queue_count_o} !== 4'd0) begin bad++; $display("FAIL fl_empty: got %b want 0", {busy_o, queue_count_o}); end
        total++; if ({chan_done_o, chan_error_o} !== 8'h00) begin bad++; $display("FAIL fl_no_flags: got %h want 00", {chan_done_o, chan_error_o}); end
        step(1);
        total++; if (fft_reset_o !== 1'b0) begin bad++; $display("FAIL fl_reset_pulse: got %b want 0", fft_reset_o); end
        check_dispatch("fl_first");
        sb.delete();
        step(6);
        total++; if (obs.size() != 0) begin bad++; $display("FAIL fl_no_dispatch: got %0d starts want 0", obs.size()); end
    endtask

    task automatic test_reset_midjob();
        send_job(2'd1, 4'd12, 1'b1);
        check_dispatch("rm_dispatch");
        step(2);
        reset_n_i = 1'b0; #1;
        total++; if ({busy_o, active_chan_o, fft_length_log2_o} !== 15'd0) begin bad++; $display("FAIL rm_async: got %h want 0", {busy_o, active_chan_o, fft_length_log2_o}); end
        step(1);
        total++; if ({fft_reset_o, chan_done_o, chan_error_o} !== 9'd0) begin bad++; $display("FAIL rm_no_flags: got %h want 0", {fft_reset_o, chan_done_o, chan_error_o}); end
        total++; if (chan_scale_o !== 32'h0) begin bad++; $display("FAIL rm_scale: got %h want 0", chan_scale_o); end
        reset_n_i = 1'b1;
        step(4);
        total++; if (obs.size() != 0 || job_ready_o !== 1'b1) begin bad++; $display("FAIL rm_after: starts=%0d ready=%b want 0/1", obs.size(), job_ready_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal_len();
        test_back_to_back();
        test_timeout();
        test_done_error();
        test_flush();
        test_reset_midjob();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
